front_panel: RTL and testbench

Board-side front panel for the 16-bit CPU controller. It turns raw, bouncing push-buttons into the single-cycle `exec` and `cpuReset` pulses the controller samples. It also synchronizes the data switches onto the controller's input bus, and time-multiplexes the controller's 16-bit result (or IR debug word) onto a 4-digit 7-segment display with phase LEDs.

---
 rtl/front_panel.sv | 223 ++++++++++++++++++++++
 tb/tb_front_panel.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/front_panel.sv
// front_panel: board-side front panel for the 16-bit CPU controller.
// - Two push-buttons: 2-flop synchronizer, then a debouncer, then a
//   registered rising-edge pulse (exec / cpuReset).
// - Data switches: 2-flop synchronizer onto inData.
// - 4-digit multiplexed 7-segment display of the result word, plus
//   phase LEDs.
// Optional feature macro: FRONT_PANEL_DEBUG_VIEW_EN. When it is defined,
// viewSel selects the debug word (IR) as the display source.
module front_panel #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] SCAN_DIV        = 16'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btnExec,
  input  logic        btnReset,
  input  logic [15:0] switches,
  input  logic        viewSel,
  input  logic [15:0] result,
  input  logic [15:0] debug,
  input  logic [4:0]  phase,
  output logic        exec,
  output logic        cpuReset,
  output logic [15:0] inData,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [4:0]  leds
);

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  logic        exec_sync1_q, exec_sync1_d;
  logic        exec_sync2_q, exec_sync2_d;
  logic        rst_sync1_q, rst_sync1_d;
  logic        rst_sync2_q, rst_sync2_d;

  logic [15:0] exec_cnt_q, exec_cnt_d;
  logic        exec_stable_q, exec_stable_d;
  logic        exec_stable_dly_q, exec_stable_dly_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;
  logic        rst_stable_q, rst_stable_d;
  logic        rst_stable_dly_q, rst_stable_dly_d;

  logic        exec_pulse_q, exec_pulse_d;
  logic        cpu_reset_pulse_q, cpu_reset_pulse_d;

  logic [15:0] sw_sync1_q, sw_sync1_d;
  logic [15:0] sw_sync2_q, sw_sync2_d;

  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [4:0]  leds_q, leds_d;

  logic [15:0] disp_src;
  logic [3:0]  disp_nib;
  logic        exec_rise;
  logic        rst_rise;

  // ---------------------------------------------------------------
  // Display source selection
  // ---------------------------------------------------------------
`ifdef FRONT_PANEL_DEBUG_VIEW_EN
  assign disp_src = viewSel ? debug : result;
`else
  // viewSel and debug have no function in this build.
  logic [16:0] unused_view_inputs;
  assign unused_view_inputs = {viewSel, debug};
  assign disp_src = result;
`endif

  // Two-flop synchronizers for both buttons and the switch bank.
  always_comb begin
    exec_sync1_d = btnExec;
    exec_sync2_d = exec_sync1_q;
    rst_sync1_d  = btnReset;
    rst_sync2_d  = rst_sync1_q;
    sw_sync1_d   = switches;
    sw_sync2_d   = sw_sync1_q;
  end

  // Exec debouncer: count consecutive differing samples, flip on the Nth.
  always_comb begin
    exec_cnt_d    = exec_cnt_q;
    exec_stable_d = exec_stable_q;
    if (exec_sync2_q != exec_stable_q) begin
      if (exec_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        exec_stable_d = ~exec_stable_q;
        exec_cnt_d    = 16'd0;
      end else begin
        exec_cnt_d = exec_cnt_q + 16'd1;
      end
    end else begin
      exec_cnt_d = 16'd0;
    end
  end

  // Reset-button debouncer: identical behaviour to the exec debouncer.
  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    rst_stable_d = rst_stable_q;
    if (rst_sync2_q != rst_stable_q) begin
      if (rst_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        rst_stable_d = ~rst_stable_q;
        rst_cnt_d    = 16'd0;
      end else begin
        rst_cnt_d = rst_cnt_q + 16'd1;
      end
    end else begin
      rst_cnt_d = 16'd0;
    end
  end

  // Rising-edge pulses. A simultaneous reset press wins over exec, so the
  // two pulses can never be high together.
  always_comb begin
    exec_stable_dly_d = exec_stable_q;
    rst_stable_dly_d  = rst_stable_q;
    exec_rise         = exec_stable_q & ~exec_stable_dly_q;
    rst_rise          = rst_stable_q & ~rst_stable_dly_q;
    cpu_reset_pulse_d = rst_rise;
    exec_pulse_d      = exec_rise & ~rst_rise;
  end

  // Display scan: digit period of SCAN_DIV cycles. an and seg are computed
  // from the next digit so that both change on the same edge.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_DIV - 16'd1) begin
      scan_cnt_d = 16'd0;
      digit_d    = digit_q + 2'd1;
    end
    case (digit_d)
      2'd0:    disp_nib = disp_src[3:0];
      2'd1:    disp_nib = disp_src[7:4];
      2'd2:    disp_nib = disp_src[11:8];
      default: disp_nib = disp_src[15:12];
    endcase
    an_d   = ~(4'b0001 << digit_d);
    seg_d  = hex_font(disp_nib);
    leds_d = phase;
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      exec_sync1_q      <= 1'b0;
      exec_sync2_q      <= 1'b0;
      rst_sync1_q       <= 1'b0;
      rst_sync2_q       <= 1'b0;
      exec_cnt_q        <= 16'd0;
      exec_stable_q     <= 1'b0;
      exec_stable_dly_q <= 1'b0;
      rst_cnt_q         <= 16'd0;
      rst_stable_q      <= 1'b0;
      rst_stable_dly_q  <= 1'b0;
      exec_pulse_q      <= 1'b0;
      cpu_reset_pulse_q <= 1'b0;
      sw_sync1_q        <= 16'd0;
      sw_sync2_q        <= 16'd0;
      scan_cnt_q        <= 16'd0;
      digit_q           <= 2'd0;
      an_q              <= 4'b1110;
      seg_q             <= 7'b1000000;
      leds_q            <= 5'd0;
    end else begin
      exec_sync1_q      <= exec_sync1_d;
      exec_sync2_q      <= exec_sync2_d;
      rst_sync1_q       <= rst_sync1_d;
      rst_sync2_q       <= rst_sync2_d;
      exec_cnt_q        <= exec_cnt_d;
      exec_stable_q     <= exec_stable_d;
      exec_stable_dly_q <= exec_stable_dly_d;
      rst_cnt_q         <= rst_cnt_d;
      rst_stable_q      <= rst_stable_d;
      rst_stable_dly_q  <= rst_stable_dly_d;
      exec_pulse_q      <= exec_pulse_d;
      cpu_reset_pulse_q <= cpu_reset_pulse_d;
      sw_sync1_q        <= sw_sync1_d;
      sw_sync2_q        <= sw_sync2_d;
      scan_cnt_q        <= scan_cnt_d;
      digit_q           <= digit_d;
      an_q              <= an_d;
      seg_q             <= seg_d;
      leds_q            <= leds_d;
    end
  end

  assign exec     = exec_pulse_q;
  assign cpuReset = cpu_reset_pulse_q;
  assign inData   = sw_sync2_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_front_panel.sv
// tb_front_panel: directed bench for front_panel with DEBOUNCE_CYCLES=4,
// SCAN_DIV=4. Inputs are driven 1 ns after a rising edge; outputs are
// sampled at the same point, so "edge k" below is the k-th rising edge
// after an input change.
module tb_front_panel;

  logic        clock;
  logic        reset;
  logic        btnExec;
  logic        btnReset;
  logic [15:0] switches;
  logic        viewSel;
  logic [15:0] result;
  logic [15:0] debug;
  logic [4:0]  phase;
  logic        exec;
  logic        cpuReset;
  logic [15:0] inData;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [4:0]  leds;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  // Expected digit enables per digit index.
  logic [3:0] an_tab[4]       = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  // result = 16'h12AF, digits 0..3 = F, A, 2, 1.
  logic [6:0] seg_12af[4]     = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
  // debug = 16'hC0DE, digits 0..3 = E, d, 0, C.
  logic [6:0] seg_c0de[4]     = '{7'b0000110, 7'b0100001, 7'b1000000, 7'b1000110};
  logic [15:0] sw_vec[6]      = '{16'hBEEF, 16'h0001, 16'h8000, 16'hFFFF, 16'h5A5A, 16'h0000};
  logic        bounce_pat[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  front_panel #(
    .DEBOUNCE_CYCLES(16'd4),
    .SCAN_DIV       (16'd4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btnExec (btnExec),
    .btnReset(btnReset),
    .switches(switches),
    .viewSel (viewSel),
    .result  (result),
    .debug   (debug),
    .phase   (phase),
    .exec    (exec),
    .cpuReset(cpuReset),
    .inData  (inData),
    .an      (an),
    .seg     (seg),
    .leds    (leds)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_exec", {31'd0, exec}, 32'd0);
    check("rst_cpureset", {31'd0, cpuReset}, 32'd0);
    check("rst_indata", {16'd0, inData}, 32'd0);
    check("rst_leds", {27'd0, leds}, 32'd0);
    check("rst_an", {28'd0, an}, 32'hE);
    check("rst_seg", {25'd0, seg}, 32'h40);
  endtask

  // Walk 16 cycles after a reset and compare the scan against a digit table.
  task automatic check_scan(input string tag, input logic [6:0] tab[4]);
    for (int j = 1; j <= 16; j++) begin
      tick();
      check({tag, "_an"}, {28'd0, an}, {28'd0, an_tab[(j / 4) % 4]});
      check({tag, "_seg"}, {25'd0, seg}, {25'd0, tab[(j / 4) % 4]});
    end
  endtask

  initial begin
    reset    = 1'b1;
    btnExec  = 1'b0;
    btnReset = 1'b0;
    switches = 16'd0;
    viewSel  = 1'b0;
    result   = 16'd0;
    debug    = 16'd0;
    phase    = 5'd0;
    tick();
    tick();
    check_reset_values();
    reset = 1'b0;

    // Idle: no pulses, display scans zeros.
    for (int j = 1; j <= 50; j++) begin
      tick();
      check("idle_exec", {31'd0, exec}, 32'd0);
      check("idle_cpureset", {31'd0, cpuReset}, 32'd0);
      check("idle_indata", {16'd0, inData}, 32'd0);
      check("idle_seg", {25'd0, seg}, 32'h40);
      check("idle_an", {28'd0, an}, {28'd0, an_tab[(j / 4) % 4]});
    end

    // Clean exec press held 20 cycles: pulse on edge 6 only.
    for (int k = 0; k < 20; k++) begin
      btnExec = 1'b1;
      tick();
      check("clean_exec", {31'd0, exec}, {31'd0, (k == 6)});
      check("clean_cpureset", {31'd0, cpuReset}, 32'd0);
    end
    for (int k = 0; k < 20; k++) begin
      btnExec = 1'b0;
      tick();
      check("release_exec", {31'd0, exec}, 32'd0);
    end

    // Bouncy press: last 0->1 sample at edge 3, pulse at edge 9.
    for (int k = 0; k < 20; k++) begin
      btnExec = (k < 7) ? bounce_pat[k] : 1'b1;
      tick();
      check("bounce_exec", {31'd0, exec}, {31'd0, (k == 9)});
    end
    for (int k = 0; k < 20; k++) begin
      btnExec = 1'b0;
      tick();
      check("bounce_rel_exec", {31'd0, exec}, 32'd0);
    end

    // Both buttons together: cpuReset on edge 6, exec suppressed.
    for (int k = 0; k < 20; k++) begin
      btnExec  = 1'b1;
      btnReset = 1'b1;
      tick();
      check("both_cpureset", {31'd0, cpuReset}, {31'd0, (k == 6)});
      check("both_exec", {31'd0, exec}, 32'd0);
    end
    for (int k = 0; k < 20; k++) begin
      btnExec  = 1'b0;
      btnReset = 1'b0;
      tick();
      check("both_rel_exec", {31'd0, exec}, 32'd0);
      check("both_rel_cpureset", {31'd0, cpuReset}, 32'd0);
    end

    // Phase LEDs are a one-cycle registered copy.
    phase = 5'b00100;
    tick();
    check("leds_a", {27'd0, leds}, 32'h04);
    phase = 5'b10000;
    tick();
    check("leds_b", {27'd0, leds}, 32'h10);

    // Switches reach inData two edges after they change.
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 6; i++) begin
      switches = sw_vec[i];
      exp_q.push_back(sw_vec[i]);
      tick();
      check("indata", {16'd0, inData}, {16'd0, exp_q.pop_front()});
    end

    // Reset mid-debounce with exec held through it: pulse 7 edges after
    // the last reset-high edge.
    btnExec = 1'b1;
    tick();
    tick();
    tick();
    pulse_reset();
    check_reset_values();
    for (int j = 1; j <= 12; j++) begin
      tick();
      check("held_rst_exec", {31'd0, exec}, {31'd0, (j == 7)});
    end
    btnExec = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      check("held_rel_exec", {31'd0, exec}, 32'd0);
    end

    // Result display 16'h12AF, then a mid-digit change on digit 0.
    result = 16'h12AF;
    pulse_reset();
    check_scan("scan_12af", seg_12af);
    result = 16'h12A3;
    tick();
    check("seg_update", {25'd0, seg}, 32'h30);
    check("seg_update_an", {28'd0, an}, 32'hE);

    // Debug view select.
    result  = 16'h12AF;
    debug   = 16'hC0DE;
    viewSel = 1'b1;
    pulse_reset();
`ifdef FRONT_PANEL_DEBUG_VIEW_EN
    check_scan("scan_debug", seg_c0de);
`else
    check_scan("scan_noview", seg_12af);
`endif
    viewSel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
